// File: rtl/tile_writeback_pkg.sv
// Shared constants and types for the tile-to-framebuffer copy engine.
package tile_writeback_pkg;
    localparam int TILE_DIM    = 32;
    localparam int TILE_PIXELS = TILE_DIM * TILE_DIM;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TILE,
        PREFETCH,
        WRITE,
        FINISH
    } state_t;

    typedef logic [15:0] rgb565_t;
endpackage

// File: rtl/tile_writeback_fb_addr_gen.sv
// Framebuffer address generator: one multiply at start, then pure add stepping
// along the tile row and a stride jump at the end of each row.
module fb_addr_gen #(
    parameter int FB_STRIDE = 640,
    parameter int TILE_DIM  = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic        col_last,
    input  logic [31:0] fb_base,
    input  logic [4:0]  tile_x,
    input  logic [4:0]  tile_y,
    output logic [31:0] addr
);
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic [31:0] base_off;

    always_comb begin
        base_off = (32'(tile_y) * 32'(TILE_DIM) * 32'(FB_STRIDE)
                  + 32'(tile_x) * 32'(TILE_DIM)) << 1;
        addr_d   = addr_q;
        if (load)
            addr_d = fb_base + base_off;
        else if (step)
            // Leaving column 31 lands on column 0 of the next framebuffer row.
            addr_d = col_last ? addr_q + 32'(2 * (FB_STRIDE - TILE_DIM + 1))
                              : addr_q + 32'd2;
    end

    always_ff @(posedge clk) begin
        if (!resetn) addr_q <= '0;
        else         addr_q <= addr_d;
    end

    assign addr = addr_q;
endmodule

// File: rtl/tile_writeback.sv
// Copies one 32x32 RGB565 tile from the tile RAM to the framebuffer over Avalon-MM.
module tile_writeback #(
    parameter int FB_STRIDE = 640,
    parameter int TILE_DIM  = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [4:0]  tile_x,
    input  logic [4:0]  tile_y,
    input  logic [31:0] fb_base,
    input  logic        tile_done,
    output logic [9:0]  tile_addr,
    input  logic [15:0] tile_data,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [15:0] avm_writedata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done
);
    import tile_writeback_pkg::*;

    state_t     state_q, state_d;
    logic [9:0] p_q, p_d;
    logic       load;
    logic       accept;

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        load          = 1'b0;
        accept        = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = '0;
        tile_addr     = '0;
        busy          = (state_q != IDLE);
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_TILE;
                    p_d     = '0;
                    load    = 1'b1;
                end
            end
            WAIT_TILE: begin
                if (tile_done) state_d = PREFETCH;
            end
            PREFETCH: begin
                state_d = WRITE;
            end
            WRITE: begin
                avm_write     = 1'b1;
                avm_writedata = rgb565_t'(tile_data);
                accept        = !avm_waitrequest;
                // Hold the RAM address while stalled so the read data stays put.
                tile_addr     = accept ? p_q + 10'd1 : p_q;
                if (accept) begin
                    p_d = p_q + 10'd1;
                    if (p_q == 10'(TILE_PIXELS - 1)) state_d = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
        end
    end

    fb_addr_gen #(
        .FB_STRIDE(FB_STRIDE),
        .TILE_DIM (TILE_DIM)
    ) u_addr (
        .clk     (clk),
        .resetn  (resetn),
        .load    (load),
        .step    (accept),
        .col_last(p_q[4:0] == 5'd31),
        .fb_base (fb_base),
        .tile_x  (tile_x),
        .tile_y  (tile_y),
        .addr    (avm_address)
    );
endmodule
